// File: rtl/writeback_queue.sv
// Purpose: in-order writeback queue that arbitrates ALU/MEM results and drives the
//          32x32 register file write port, with forwarding lookups over pending writes.
// Latency: a write accepted at edge N is on WriteRg/WriteData/RegWrite after edge N+1.
// Backpressure: AluReady/MemReady drop when the FIFO holds DEPTH entries (start-of-cycle
//          Count only, no same-cycle pop credit); ALU has fixed priority over MEM.
// Ports:
//   Clock, Reset          rising-edge clock, synchronous active-low reset
//   Alu*/Mem*             producer write requests (Valid/Rg/Data in, Ready out)
//   WriteRg/WriteData/RegWrite  registered register file write port
//   ReadRg1/2, FwdN*      forwarding lookups: youngest pending write to ReadRgN
//   Count                 occupied FIFO entries, 0..DEPTH
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        AluValid,
  input  logic [4:0]  AluRg,
  input  logic [31:0] AluData,
  output logic        AluReady,
  input  logic        MemValid,
  input  logic [4:0]  MemRg,
  input  logic [31:0] MemData,
  output logic        MemReady,
  output logic [4:0]  WriteRg,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  input  logic [4:0]  ReadRg1,
  input  logic [4:0]  ReadRg2,
  output logic        Fwd1Valid,
  output logic [31:0] Fwd1Data,
  output logic        Fwd2Valid,
  output logic [31:0] Fwd2Data,
  output logic [AW:0] Count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]       entRg    [DEPTH];
  logic [31:0]      entData  [DEPTH];
  logic [DEPTH-1:0] entValid;
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      cnt;

  logic        notFull;
  logic        aluFire;
  logic        memFire;
  logic [4:0]  pushRg;
  logic [31:0] pushData;
  logic        enq;
  logic        deq;

  assign notFull  = (cnt < FULL);
  assign AluReady = notFull;
  assign MemReady = notFull && !AluValid;
  assign aluFire  = AluValid && AluReady;
  assign memFire  = MemValid && MemReady;
  assign pushRg   = aluFire ? AluRg : MemRg;
  assign pushData = aluFire ? AluData : MemData;
  // Writes to r0 complete the handshake but never occupy a slot.
  assign enq      = (aluFire || memFire) && (pushRg != 5'd0);
  assign deq      = (cnt != '0);
  assign Count    = cnt;

  // Entry payload needs no reset: occupancy is tracked by entValid and cnt.
  always_ff @(posedge Clock) begin
    if (enq) begin
      entRg[wrPtr]   <= pushRg;
      entData[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      cnt       <= '0;
      entValid  <= '0;
      RegWrite  <= 1'b0;
      WriteRg   <= 5'd0;
      WriteData <= 32'd0;
    end else begin
      // enq and deq never hit the same slot: enq needs a free slot, deq an occupied one.
      if (enq) begin
        entValid[wrPtr] <= 1'b1;
        wrPtr           <= wrPtr + 1'b1;
      end
      if (deq) begin
        RegWrite        <= 1'b1;
        WriteRg         <= entRg[rdPtr];
        WriteData       <= entData[rdPtr];
        entValid[rdPtr] <= 1'b0;
        rdPtr           <= rdPtr + 1'b1;
      end else begin
        RegWrite  <= 1'b0;
        WriteRg   <= 5'd0;
        WriteData <= 32'd0;
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Scan oldest to youngest (output stage, then FIFO from the head) so the
  // last match seen is the youngest pending write.
  function automatic logic [32:0] lookup(input logic [4:0] rg);
    logic          hit;
    logic [31:0]   dat;
    logic [AW-1:0] idx;
    hit = 1'b0;
    dat = 32'd0;
    idx = '0;
    if (rg != 5'd0) begin
      if (RegWrite && (WriteRg == rg)) begin
        hit = 1'b1;
        dat = WriteData;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rdPtr + i[AW-1:0];
        if (entValid[idx] && (entRg[idx] == rg)) begin
          hit = 1'b1;
          dat = entData[idx];
        end
      end
    end
    return {hit, dat};
  endfunction

  assign {Fwd1Valid, Fwd1Data} = lookup(ReadRg1);
  assign {Fwd2Valid, Fwd2Data} = lookup(ReadRg2);

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        AluValid = 1'b0;
  logic [4:0]  AluRg = '0;
  logic [31:0] AluData = '0;
  logic        AluReady;
  logic        MemValid = 1'b0;
  logic [4:0]  MemRg = '0;
  logic [31:0] MemData = '0;
  logic        MemReady;
  logic [4:0]  WriteRg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [4:0]  ReadRg1 = '0;
  logic [4:0]  ReadRg2 = '0;
  logic        Fwd1Valid;
  logic [31:0] Fwd1Data;
  logic        Fwd2Valid;
  logic [31:0] Fwd2Data;
  logic [AW:0] Count;

  writeback_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset),
    .AluValid(AluValid), .AluRg(AluRg), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemRg(MemRg), .MemData(MemData), .MemReady(MemReady),
    .WriteRg(WriteRg), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadRg1(ReadRg1), .ReadRg2(ReadRg2),
    .Fwd1Valid(Fwd1Valid), .Fwd1Data(Fwd1Data),
    .Fwd2Valid(Fwd2Valid), .Fwd2Data(Fwd2Data),
    .Count(Count)
  );

  always #5 Clock = ~Clock;

  int nVec = 0;
  int nErr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending writes as a plain queue {rg, data}, oldest at front,
  // plus the registered write port contents.
  logic [36:0] mq[$];
  bit          mOutV = 0;
  logic [4:0]  mOutRg = '0;
  logic [31:0] mOutData = '0;
  bit          known = 0;

  always @(posedge Clock) begin
    if (!Reset) begin
      mq.delete();
      mOutV = 0; mOutRg = '0; mOutData = '0;
      known = 1;
    end else if (known) begin
      bit          acc;
      logic [4:0]  rg;
      logic [31:0] dt;
      acc = 0; rg = '0; dt = '0;
      if (AluValid && mq.size() < DEPTH) begin
        acc = 1; rg = AluRg; dt = AluData;
      end else if (MemValid && mq.size() < DEPTH) begin
        acc = 1; rg = MemRg; dt = MemData;
      end
      if (mq.size() > 0) begin
        logic [36:0] h;
        h = mq.pop_front();
        mOutV = 1; mOutRg = h[36:32]; mOutData = h[31:0];
      end else begin
        mOutV = 0; mOutRg = '0; mOutData = '0;
      end
      if (acc && rg != 5'd0) mq.push_back({rg, dt});
    end
  end

  function automatic logic [32:0] fwdModel(input logic [4:0] rg);
    logic        v;
    logic [31:0] d;
    v = 0; d = '0;
    if (rg != 5'd0) begin
      if (mOutV && mOutRg == rg) begin v = 1; d = mOutData; end
      foreach (mq[i]) if (mq[i][36:32] == rg) begin v = 1; d = mq[i][31:0]; end
    end
    return {v, d};
  endfunction

  // Compare process: every cycle once the model is anchored by a reset.
  always @(negedge Clock) begin
    if (known) begin
      logic [32:0] f1;
      logic [32:0] f2;
      bit          room;
      f1 = fwdModel(ReadRg1);
      f2 = fwdModel(ReadRg2);
      room = (mq.size() < DEPTH);
      chk("Count",     32'(Count),     32'(mq.size()));
      chk("AluReady",  32'(AluReady),  32'(room));
      chk("MemReady",  32'(MemReady),  32'(room && !AluValid));
      chk("RegWrite",  32'(RegWrite),  32'(mOutV));
      chk("WriteRg",   32'(WriteRg),   32'(mOutRg));
      chk("WriteData", WriteData,      mOutData);
      chk("Fwd1Valid", 32'(Fwd1Valid), 32'(f1[32]));
      chk("Fwd1Data",  Fwd1Data,       f1[31:0]);
      chk("Fwd2Valid", 32'(Fwd2Valid), 32'(f2[32]));
      chk("Fwd2Data",  Fwd2Data,       f2[31:0]);
    end
  end

  task automatic step;
    @(posedge Clock);
    #2;
  endtask

  task automatic atNeg;
    @(negedge Clock);
  endtask

  initial begin
    // Basic single write through an empty queue.
    step; step;
    Reset = 1'b1;
    AluValid = 1'b1; AluRg = 5'd5; AluData = 32'h1234;
    atNeg; chk("t1 AluReady", 32'(AluReady), 32'd1); chk("t1 Count0", 32'(Count), 32'd0);
    step; AluValid = 1'b0;
    atNeg; chk("t1 Count1", 32'(Count), 32'd1); chk("t1 RegWrite early", 32'(RegWrite), 32'd0);
    step;
    atNeg; chk("t1 RegWrite", 32'(RegWrite), 32'd1); chk("t1 WriteRg", 32'(WriteRg), 32'd5);
    chk("t1 WriteData", WriteData, 32'h1234); chk("t1 Count drained", 32'(Count), 32'd0);
    step;
    atNeg; chk("t1 RegWrite off", 32'(RegWrite), 32'd0);

    // ALU priority over MEM, MEM held until accepted.
    AluValid = 1'b1; AluRg = 5'd3; AluData = 32'hA;
    MemValid = 1'b1; MemRg = 5'd4; MemData = 32'hB;
    atNeg; chk("t2 MemReady blocked", 32'(MemReady), 32'd0);
    step; AluValid = 1'b0;
    atNeg; chk("t2 MemReady", 32'(MemReady), 32'd1);
    step; MemValid = 1'b0;
    atNeg; chk("t2 commit rg3", 32'(WriteRg), 32'd3); chk("t2 data A", WriteData, 32'hA);
    step;
    atNeg; chk("t2 commit rg4", 32'(WriteRg), 32'd4); chk("t2 data B", WriteData, 32'hB);
    step;

    // Sustained pushes: commits follow one edge behind, pointers wrap.
    for (int k = 1; k <= 6; k++) begin
      AluValid = 1'b1; AluRg = 5'(k); AluData = 32'h100 + 32'(k);
      step;
      atNeg;
      if (k >= 2) chk("t3 order", 32'(WriteRg), 32'(k - 1));
    end
    AluValid = 1'b0;
    step; step;

    // Forwarding of the youngest pending write.
    ReadRg1 = 5'd7; ReadRg2 = 5'd0;
    AluValid = 1'b1; AluRg = 5'd7; AluData = 32'h11;
    atNeg; chk("t4 none pending", 32'(Fwd1Valid), 32'd0);
    step; AluData = 32'h22;
    atNeg; chk("t4 fwd 11", Fwd1Data, 32'h11); chk("t4 fwd valid", 32'(Fwd1Valid), 32'd1);
    step; AluValid = 1'b0;
    atNeg; chk("t4 fwd 22", Fwd1Data, 32'h22);
    chk("t4 fwd2 valid", 32'(Fwd2Valid), 32'd0); chk("t4 fwd2 data", Fwd2Data, 32'd0);
    step;
    atNeg; chk("t4 fwd 22 out", Fwd1Data, 32'h22);
    step;
    atNeg; chk("t4 committed", 32'(Fwd1Valid), 32'd0);

    // r0 writes are dropped.
    AluValid = 1'b1; AluRg = 5'd0; AluData = 32'hFFFF;
    step; AluValid = 1'b0;
    atNeg; chk("t5 Count", 32'(Count), 32'd0); chk("t5 RegWrite", 32'(RegWrite), 32'd0);
    step;
    atNeg; chk("t5 RegWrite later", 32'(RegWrite), 32'd0);

    // Reset mid-operation discards pending writes.
    ReadRg1 = 5'd12; ReadRg2 = 5'd11;
    for (int k = 10; k <= 12; k++) begin
      AluValid = 1'b1; AluRg = 5'(k); AluData = 32'(k);
      step;
    end
    AluValid = 1'b0; Reset = 1'b0;
    step; Reset = 1'b1;
    atNeg; chk("t6 Count", 32'(Count), 32'd0); chk("t6 RegWrite", 32'(RegWrite), 32'd0);
    chk("t6 Fwd1", 32'(Fwd1Valid), 32'd0); chk("t6 Fwd2", 32'(Fwd2Valid), 32'd0);
    step;
    atNeg; chk("t6 no commit", 32'(RegWrite), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      Reset    = ($urandom_range(0, 99) != 0);
      AluValid = $urandom_range(0, 1);
      AluRg    = 5'($urandom_range(0, 7));
      AluData  = $urandom;
      MemValid = $urandom_range(0, 1);
      MemRg    = 5'($urandom_range(0, 7));
      MemData  = $urandom;
      ReadRg1  = 5'($urandom_range(0, 7));
      ReadRg2  = 5'($urandom_range(0, 7));
      step;
    end
    AluValid = 1'b0; MemValid = 1'b0;
    step; step;
    atNeg;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
